hps_key_in: RTL and testbench
=============================

Name: hps_key_in

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO. It samples external push-buttons/switches and exposes them to the HPS.
- Synchronises raw inputs, detects edges, latches them in a write-1-to-clear capture register and raises a maskable interrupt.
- Sits on the HPS lightweight bridge beside the LED PIO. The game software polls it or takes its irq for player input.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- EDGE_TYPE, 0, capture condition: 0 = rising, 1 = falling, 2 = any edge.
- DEBOUNCE_CYCLES, 50000, stable-clock count required before a change is accepted (used only with DEBOUNCE_EN); minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  raw asynchronous external inputs.
- readdata  output  32  read data, zero wait states, combinational from address.
- irq  output  1  level interrupt, active-high.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Reset clears every register below, and irq = 0.
- Synchroniser: two flops s1 <= in_port, s2 <= s1. "Level" = s2, or the debounced value with DEBOUNCE_EN.
- prev <= level every clock.
- Edge vector: rising = level & ~prev; falling = ~level & prev; any = level ^ prev, selected by EDGE_TYPE.
- Settle counter:
  - 2-bit saturating counter, reset to 0, increments each clock until 3.
  - Edge detection is suppressed while the counter < 3, so inputs held high through reset produce no spurious capture.
- Register map (read: readdata[WIDTH-1:0] = value, upper bits 0):
  - addr 0 DATA: current level; read-only, writes ignored.
  - addr 1: reads 0; writes ignored.
  - addr 2 IRQMASK: RW; write when chipselect & ~write_n loads writedata[WIDTH-1:0].
  - addr 3 EDGECAP: read returns capture bits. Write clears each bit where writedata bit = 1 (W1C).
- Capture: cap[i] <= (cap[i] & ~clr[i]) | edge[i]. An edge in the same cycle as a W1C clear of that bit wins: the bit stays 1.
- irq = |(cap & irqmask), combinational from the registers, no extra latency.
- Latency without debounce, in_port change to visibility:
  - DATA after 2 clock edges.
  - cap and irq after 3 clock edges.
- Pulses shorter than one clock may be missed. That is acceptable.
- Reset asserted mid-operation clears cap, mask, sync, prev and settle immediately. Pending interrupts are lost.
- Write to DATA or addr 1 has no side effect. A read has no side effect: a capture is never cleared by reading.

Optional Feature:
- Macro HPS_KEY_IN_DEBOUNCE_EN.
- Defined:
  - Per-bit counter with width clog2(DEBOUNCE_CYCLES+1).
  - While s2[i] == filt[i], the counter resets to 0.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, filt[i] <= s2[i] and the counter clears.
  - Level = filt, reset value 0. Latency to DATA = 2 + DEBOUNCE_CYCLES edges.
  - Bounces shorter than DEBOUNCE_CYCLES never change filt.
- Undefined: no counters, level = s2, latencies as above.

Test Plan:
- Reset with in_port = 4'hF held, then run 10 clocks:
  - DATA reads 0x0000000F.
  - EDGECAP reads 0 and irq = 0 (settle suppression).
- EDGE_TYPE = 0, IRQMASK = 0x1, in_port[0] 0->1:
  - DATA[0] = 1 after 2 edges.
  - EDGECAP = 0x1 and irq = 1 after 3 edges.
  - Write 0x1 to addr 3 -> EDGECAP = 0 and irq = 0 on the next cycle.
- IRQMASK = 0, rising edge on bit 2:
  - EDGECAP = 0x4, irq stays 0.
  - Then write IRQMASK = 0x4 -> irq = 1 the following cycle.
- W1C write to addr 3 with writedata = 0x2 on the exact cycle a new bit-1 edge is detected -> EDGECAP[1] remains 1.
- Reset asserted while EDGECAP = 0x3 and IRQMASK = 0xF -> immediately EDGECAP = 0, IRQMASK = 0, irq = 0, with no clock required.
- With HPS_KEY_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES = 8:
  - A 5-clock glitch on bit 0 -> DATA stays 0, no capture.
  - A steady high -> DATA[0] = 1 exactly 10 edges after the change, capture one edge later.

Source files
------------

// File: rtl/hps_key_in.sv
// hps_key_in: Avalon-MM input PIO with sync, edge capture (W1C), maskable irq; optional debounce via HPS_KEY_IN_DEBOUNCE_EN
module hps_key_in #(
  parameter int WIDTH = 4,
  parameter int EDGE_TYPE = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] s1, s2, level, prev, mask, cap, edg, clr;
  logic [1:0] settle;
  logic wr;
`ifdef HPS_KEY_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0] filt;
  logic [CW-1:0] cnt [WIDTH];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= '0;
      for (int k = 0; k < WIDTH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (s2[k] == filt[k]) cnt[k] <= '0;
        else if (cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt[k] <= s2[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end
  assign level = filt;
`else
  assign level = s2;
`endif
  assign wr = chipselect & ~write_n;
  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign edg = settle != 2'd3 ? '0 :
               EDGE_TYPE == 0 ? level & ~prev :
               EDGE_TYPE == 1 ? ~level & prev : level ^ prev;
  assign irq = |(cap & mask);
  always_comb readdata = address == 2'd0 ? 32'(level) :
                         address == 2'd2 ? 32'(mask) :
                         address == 2'd3 ? 32'(cap) : 32'h0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      settle <= '0;
      mask <= '0;
      cap <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      prev <= level;
      settle <= settle == 2'd3 ? settle : settle + 2'd1;
      if (wr && address == 2'd2) mask <= writedata[WIDTH-1:0];
      cap <= (cap & ~clr) | edg;
    end
  end
endmodule

// File: tb/tb_hps_key_in.sv
// tb_hps_key_in: table-driven and scoreboard-checked bench for hps_key_in
module tb_hps_key_in;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0] in_port = 4'h0;
  logic [31:0] readdata;
  logic irq;
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    string nm;
    logic [31:0] d;
    logic i;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] in;
    logic we;
    logic [1:0] wa;
    logic [31:0] wd;
    int n;
    logic [1:0] ra;
    logic [31:0] ed;
    logic ei;
  } vec_t;

  hps_key_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [1:0] a, input logic [31:0] d, input logic i);
    exp_t e;
    address = a;
    sb.push_back('{nm, d, i});
    #1;
    e = sb.pop_front();
    total_cnt++;
    if (readdata === e.d && irq === e.i) pass_cnt++;
    else $display("FAIL %s: readdata=%h irq=%b expected readdata=%h irq=%b", e.nm, readdata, irq, e.d, e.i);
  endtask

  initial begin
`ifndef HPS_KEY_IN_DEBOUNCE_EN
    vec_t v[14];
    v[0]  = '{4'h0, 1'b0, 2'd0, 32'h0,  5, 2'd3, 32'h0, 1'b0};
    v[1]  = '{4'h0, 1'b1, 2'd2, 32'h1,  0, 2'd2, 32'h1, 1'b0};
    v[2]  = '{4'h1, 1'b0, 2'd0, 32'h0,  1, 2'd0, 32'h0, 1'b0};
    v[3]  = '{4'h1, 1'b0, 2'd0, 32'h0,  1, 2'd0, 32'h1, 1'b0};
    v[4]  = '{4'h1, 1'b0, 2'd0, 32'h0,  0, 2'd3, 32'h0, 1'b0};
    v[5]  = '{4'h1, 1'b0, 2'd0, 32'h0,  1, 2'd3, 32'h1, 1'b1};
    v[6]  = '{4'h1, 1'b1, 2'd3, 32'h1,  0, 2'd3, 32'h0, 1'b0};
    v[7]  = '{4'h1, 1'b1, 2'd2, 32'h0,  0, 2'd2, 32'h0, 1'b0};
    v[8]  = '{4'h5, 1'b0, 2'd0, 32'h0,  3, 2'd3, 32'h4, 1'b0};
    v[9]  = '{4'h5, 1'b1, 2'd2, 32'h4,  0, 2'd3, 32'h4, 1'b1};
    v[10] = '{4'h5, 1'b1, 2'd0, 32'hF,  0, 2'd0, 32'h5, 1'b1};
    v[11] = '{4'h5, 1'b1, 2'd1, 32'hFF, 0, 2'd1, 32'h0, 1'b1};
    v[12] = '{4'h5, 1'b0, 2'd0, 32'h0,  2, 2'd3, 32'h4, 1'b1};
    v[13] = '{4'h5, 1'b1, 2'd3, 32'h4,  0, 2'd3, 32'h0, 1'b0};
    in_port = 4'hF;
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("settle_data", 2'd0, 32'hF, 1'b0);
    chk("settle_cap", 2'd3, 32'h0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      in_port = v[k].in;
      if (v[k].we) wr(v[k].wa, v[k].wd);
      tick(v[k].n);
      chk($sformatf("vec%0d", k), v[k].ra, v[k].ed, v[k].ei);
    end
    in_port = 4'h7;
    tick(2);
    wr(2'd3, 32'h2);
    chk("w1c_vs_edge", 2'd3, 32'h2, 1'b0);
    wr(2'd3, 32'h2);
    chk("w1c_b1", 2'd3, 32'h0, 1'b0);
    wr(2'd2, 32'hF);
    in_port = 4'h4;
    tick(4);
    in_port = 4'h7;
    tick(3);
    chk("cap3", 2'd3, 32'h3, 1'b1);
    #1 reset = 1'b1;
    chk("rst_cap", 2'd3, 32'h0, 1'b0);
    chk("rst_mask", 2'd2, 32'h0, 1'b0);
    chk("rst_data", 2'd0, 32'h0, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(1);
`else
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("db_rst_data", 2'd0, 32'h0, 1'b0);
    chk("db_rst_cap", 2'd3, 32'h0, 1'b0);
    in_port = 4'h1;
    tick(5);
    in_port = 4'h0;
    tick(15);
    chk("glitch_data", 2'd0, 32'h0, 1'b0);
    chk("glitch_cap", 2'd3, 32'h0, 1'b0);
    in_port = 4'h1;
    tick(9);
    chk("db_lat9", 2'd0, 32'h0, 1'b0);
    tick(1);
    chk("db_lat10", 2'd0, 32'h1, 1'b0);
    chk("db_cap10", 2'd3, 32'h0, 1'b0);
    tick(1);
    chk("db_cap11", 2'd3, 32'h1, 1'b0);
    wr(2'd2, 32'h1);
    chk("db_irq", 2'd3, 32'h1, 1'b1);
    wr(2'd3, 32'h1);
    chk("db_w1c", 2'd3, 32'h0, 1'b0);
    in_port = 4'h3;
    tick(7);
    in_port = 4'h1;
    tick(15);
    chk("bounce_data", 2'd0, 32'h1, 1'b0);
    chk("bounce_cap", 2'd3, 32'h0, 1'b0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
